// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - pops fixed-length bursts from a show-ahead FIFO into a 2-entry stream buffer
//
// Parameters:
//   DATASIZE   - width of FIFO read data and stream data
//   BURST_LEN  - words popped per normal burst (1..ALMOST_GAP+1)
//   ALMOST_GAP - almost_empty threshold of the attached FIFO
// Ports:
//   clk          - single clock, shared with the FIFO read side
//   rst_n        - asynchronous active-low reset
//   rdata        - FIFO head word, valid whenever rempty=0
//   rempty       - FIFO empty flag
//   almost_empty - FIFO holds ALMOST_GAP or fewer words
//   rinc         - pop strobe to the FIFO, pops rdata in the same cycle
//   drain        - allow single-word bursts while almost_empty=1
//   abort        - one-cycle pulse: cancel the burst and discard buffered words
//   out_data     - stream data (oldest buffered word)
//   out_last     - out_data is the final word of its burst
//   out_valid    - stream valid
//   out_ready    - stream ready
//   busy         - controller is not IDLE
//   words_read   - free-running count of FIFO pops since reset

module fifo_burst_reader #(
    parameter int DATASIZE   = 8,
    parameter int BURST_LEN  = 4,
    parameter int ALMOST_GAP = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                rempty,
    input  logic                almost_empty,
    output logic                rinc,
    input  logic                drain,
    input  logic                abort,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [15:0]         words_read
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_BEATS = BW'(BURST_LEN);
    localparam logic [BW-1:0] ONE_BEAT    = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [BW-1:0]     beats_q;
    logic [DATASIZE:0] buf_q [2];   // {last, data}
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ;
    logic              pop;
    logic              start_burst;

    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = buf_q[rd_ptr_q][DATASIZE-1:0];
    assign out_last  = buf_q[rd_ptr_q][DATASIZE];
    assign busy      = (state_q != IDLE);

    // Next state and pop strobe. rinc looks only at buffer space, never at
    // out_ready, so the buffer absorbs up to two words of backpressure.
    always_comb begin
        state_d     = state_q;
        rinc        = 1'b0;
        start_burst = 1'b0;
        case (state_q)
            IDLE: begin
                if (!almost_empty || (drain && !rempty)) begin
                    state_d     = BURST;
                    start_burst = 1'b1;
                end
            end
            BURST: begin
                rinc = !rempty && (occ < 2'd2) && !abort;
                if (rinc && (beats_q == ONE_BEAT)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (occ == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d     = IDLE;
            start_burst = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Full bursts need the FIFO above the almost-empty mark; otherwise the
    // burst was started by drain and is a single word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q <= '0;
        end else if (abort) begin
            beats_q <= '0;
        end else if (start_burst) begin
            beats_q <= almost_empty ? ONE_BEAT : BURST_BEATS;
        end else if (rinc) begin
            beats_q <= beats_q - ONE_BEAT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ      <= 2'd0;
        end else if (abort) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ      <= 2'd0;
        end else begin
            if (rinc) begin
                buf_q[wr_ptr_q] <= {(beats_q == ONE_BEAT), rdata};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({rinc, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_read <= 16'd0;
        end else if (rinc) begin
            words_read <= words_read + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed and scoreboarded checks of fifo_burst_reader

module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rdata;
    logic        rempty;
    logic        almost_empty;
    logic        rinc;
    logic        drain = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] words_read;

    // second instance with long bursts, used only for the 16-bit wrap
    logic        rst_n_w = 1'b0;
    logic [7:0]  rdata_w;
    logic        rempty_w;
    logic        almost_empty_w;
    logic        rinc_w;
    logic        drain_w = 1'b0;
    logic [7:0]  out_data_w;
    logic        out_last_w;
    logic        out_valid_w;
    logic        busy_w;
    logic [15:0] words_read_w;

    int checks = 0;
    int errors = 0;
    int exp_words = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATASIZE(8), .BURST_LEN(4), .ALMOST_GAP(3)) dut (
        .clk(clk), .rst_n(rst_n), .rdata(rdata), .rempty(rempty),
        .almost_empty(almost_empty), .rinc(rinc), .drain(drain), .abort(abort),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .words_read(words_read)
    );

    fifo_burst_reader #(.DATASIZE(8), .BURST_LEN(256), .ALMOST_GAP(255)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .rdata(rdata_w), .rempty(rempty_w),
        .almost_empty(almost_empty_w), .rinc(rinc_w), .drain(drain_w), .abort(1'b0),
        .out_data(out_data_w), .out_last(out_last_w), .out_valid(out_valid_w),
        .out_ready(1'b1), .busy(busy_w), .words_read(words_read_w)
    );

    // FIFO model for the main instance: show-ahead, 256 deep
    logic [7:0] fmem [0:255];
    int head = 0;
    int tail = 0;
    assign rdata        = fmem[head[7:0]];
    assign rempty       = (tail == head);
    assign almost_empty = ((tail - head) <= 3);
    always @(posedge clk) if (rinc && (tail != head)) head <= head + 1;

    // FIFO model for the wrap instance: exactly 65540 words
    int wrap_pops = 0;
    assign rdata_w        = wrap_pops[7:0];
    assign rempty_w       = (wrap_pops >= 65540);
    assign almost_empty_w = ((65540 - wrap_pops) <= 255);
    always @(posedge clk) if (rinc_w) wrap_pops <= wrap_pops + 1;

    // stream capture and occupancy watch
    logic [8:0] cap [$];
    int pops = 0;
    int max_occ = 0;
    always @(negedge clk) begin
        if (out_valid && out_ready) cap.push_back({out_last, out_data});
        if (rinc) pops++;
        if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        fmem[tail[7:0]] = d;
        tail = tail + 1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", rinc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (words_read !== 16'd0) begin errors++; $display("FAIL reset_words_read got %0d want 0", words_read); end
        tick;
        tick;
        rst_n   = 1'b1;
        rst_n_w = 1'b1;
        tick;
    endtask

    task automatic test_two_bursts;
        int n;
        logic [8:0] got;
        cap.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        n = 0;
        while (!(cap.size() == 8 && !busy) && n < 100) begin tick; n++; end
        checks++; if (!(cap.size() == 8 && !busy)) begin errors++; $display("FAIL two_bursts_timeout got %0d words want 8", cap.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < cap.size()) ? cap[i] : 9'bx;
            checks++;
            if (got !== {(i == 3 || i == 7), 8'h10 + 8'(i)}) begin
                errors++; $display("FAIL two_bursts_word%0d got %h want %h", i, got, {(i == 3 || i == 7), 8'h10 + 8'(i)});
            end
        end
        exp_words = exp_words + 8;
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL two_bursts_words_read got %0d want %0d", words_read, exp_words); end
    endtask

    task automatic test_backpressure;
        int n;
        logic [8:0] got;
        cap.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            tick;
            if (i >= 2) begin
                checks++;
                if (out_data !== 8'h10 || out_valid !== 1'b1 || rinc !== 1'b0) begin
                    errors++; $display("FAIL hold_cycle%0d got data=%h valid=%b rinc=%b want 10/1/0", i, out_data, out_valid, rinc);
                end
            end
        end
        checks++; if (words_read !== 16'(exp_words + 2)) begin errors++; $display("FAIL hold_pops got %0d want %0d", words_read, exp_words + 2); end
        out_ready = 1'b1;
        n = 0;
        while (!(cap.size() == 8 && !busy) && n < 100) begin tick; n++; end
        checks++; if (!(cap.size() == 8 && !busy)) begin errors++; $display("FAIL release_timeout got %0d words want 8", cap.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < cap.size()) ? cap[i] : 9'bx;
            checks++;
            if (got !== {(i == 3 || i == 7), 8'h10 + 8'(i)}) begin
                errors++; $display("FAIL release_word%0d got %h want %h", i, got, {(i == 3 || i == 7), 8'h10 + 8'(i)});
            end
        end
        exp_words = exp_words + 8;
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL release_words_read got %0d want %0d", words_read, exp_words); end
    endtask

    task automatic test_drain;
        int n;
        int p0;
        logic [8:0] got;
        cap.delete();
        out_ready = 1'b1;
        drain = 1'b0;
        p0 = pops;
        push_word(8'hA0);
        push_word(8'hA1);
        for (int i = 0; i < 50; i++) tick;
        checks++; if (pops != p0 || busy !== 1'b0) begin errors++; $display("FAIL no_drain got pops=%0d busy=%b want 0/0", pops - p0, busy); end
        drain = 1'b1;
        n = 0;
        while (!(cap.size() == 2 && !busy && tail == head) && n < 50) begin tick; n++; end
        checks++; if (!(cap.size() == 2 && !busy)) begin errors++; $display("FAIL drain_timeout got %0d words want 2", cap.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < cap.size()) ? cap[i] : 9'bx;
            checks++;
            if (got !== {1'b1, 8'hA0 + 8'(i)}) begin errors++; $display("FAIL drain_word%0d got %h want %h", i, got, {1'b1, 8'hA0 + 8'(i)}); end
        end
        drain = 1'b0;
        exp_words = exp_words + 2;
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL drain_words_read got %0d want %0d", words_read, exp_words); end
    endtask

    task automatic test_abort;
        int n;
        logic [8:0] got;
        cap.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
        n = 0;
        while (words_read != 16'(exp_words + 2) && n < 20) begin tick; n++; end
        checks++; if (words_read !== 16'(exp_words + 2)) begin errors++; $display("FAIL abort_setup got %0d want %0d", words_read, exp_words + 2); end
        abort = 1'b1;
        #1;
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL abort_rinc got %b want 0", rinc); end
        tick;
        abort = 1'b0;
        exp_words = exp_words + 2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL abort_words_read got %0d want %0d", words_read, exp_words); end
        out_ready = 1'b1;
        n = 0;
        while (!(cap.size() == 4 && !busy) && n < 100) begin tick; n++; end
        drain = 1'b1;
        n = 0;
        while (!(cap.size() == 6 && !busy && tail == head) && n < 100) begin tick; n++; end
        drain = 1'b0;
        checks++; if (cap.size() != 6) begin errors++; $display("FAIL abort_resume_count got %0d want 6", cap.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < cap.size()) ? cap[i] : 9'bx;
            checks++;
            if (got !== {(i >= 3), 8'h32 + 8'(i)}) begin errors++; $display("FAIL abort_word%0d got %h want %h", i, got, {(i >= 3), 8'h32 + 8'(i)}); end
        end
        exp_words = exp_words + 6;
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL abort_total got %0d want %0d", words_read, exp_words); end
    endtask

    task automatic test_async_reset;
        int n;
        int p0;
        int h0;
        logic [8:0] got;
        cap.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
        n = 0;
        while (words_read != 16'(exp_words + 2) && n < 20) begin tick; n++; end
        checks++; if (words_read !== 16'(exp_words + 2)) begin errors++; $display("FAIL arst_setup got %0d want %0d", words_read, exp_words + 2); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL arst_stream got v=%b l=%b d=%h want 0/0/00", out_valid, out_last, out_data);
        end
        checks++; if (busy !== 1'b0 || rinc !== 1'b0 || words_read !== 16'd0) begin
            errors++; $display("FAIL arst_ctrl got busy=%b rinc=%b words=%0d want 0/0/0", busy, rinc, words_read);
        end
        p0 = pops;
        h0 = head;
        for (int i = 0; i < 3; i++) tick;
        checks++; if (pops != p0 || head != h0) begin errors++; $display("FAIL arst_no_pop got %0d pops want 0", pops - p0); end
        rst_n = 1'b1;
        exp_words = 0;
        out_ready = 1'b1;
        n = 0;
        while (!(cap.size() == 4 && !busy) && n < 100) begin tick; n++; end
        drain = 1'b1;
        n = 0;
        while (!(cap.size() == 6 && !busy && tail == head) && n < 100) begin tick; n++; end
        drain = 1'b0;
        checks++; if (cap.size() != 6) begin errors++; $display("FAIL arst_resume_count got %0d want 6", cap.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < cap.size()) ? cap[i] : 9'bx;
            checks++;
            if (got !== {(i >= 3), 8'h42 + 8'(i)}) begin errors++; $display("FAIL arst_word%0d got %h want %h", i, got, {(i >= 3), 8'h42 + 8'(i)}); end
        end
        exp_words = 6;
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL arst_words_read got %0d want %0d", words_read, exp_words); end
    endtask

    task automatic test_random;
        int n;
        int fed;
        int bad;
        logic [8:0] got;
        logic [8:0] want;
        cap.delete();
        max_occ = 0;
        fed = 0;
        n = 0;
        while (!(cap.size() == 10000 && !busy && tail == head) && n < 60000) begin
            if (fed < 10000 && (tail - head) < 200) begin
                push_word(8'(fed * 7 + 3));
                fed++;
            end
            out_ready = 1'($urandom_range(0, 1));
            tick;
            n++;
        end
        out_ready = 1'b1;
        checks++; if (cap.size() != 10000) begin errors++; $display("FAIL random_count got %0d want 10000", cap.size()); end
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            got  = (i < cap.size()) ? cap[i] : 9'bx;
            want = {((i % 4) == 3), 8'(i * 7 + 3)};
            checks++;
            if (got !== want) begin
                errors++;
                if (bad < 10) $display("FAIL random_word%0d got %h want %h", i, got, want);
                bad++;
            end
        end
        exp_words = exp_words + 10000;
        checks++; if (words_read !== 16'(exp_words)) begin errors++; $display("FAIL random_words_read got %0d want %0d", words_read, exp_words); end
        checks++; if (max_occ > 2) begin errors++; $display("FAIL random_occupancy got %0d want <=2", max_occ); end
    endtask

    task automatic test_wrap;
        int n;
        n = 0;
        while (!(wrap_pops == 65536 && !busy_w) && n < 80000) begin tick; n++; end
        checks++; if (wrap_pops != 65536) begin errors++; $display("FAIL wrap_pre_pops got %0d want 65536", wrap_pops); end
        checks++; if (words_read_w !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", words_read_w); end
        drain_w = 1'b1;
        n = 0;
        while (!(wrap_pops == 65540 && !busy_w) && n < 100) begin tick; n++; end
        drain_w = 1'b0;
        checks++; if (words_read_w !== 16'd4) begin errors++; $display("FAIL wrap_four got %0d want 4", words_read_w); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) fmem[i] = 8'h00;
        test_reset;
        test_two_bursts;
        test_backpressure;
        test_drain;
        test_abort;
        test_async_reset;
        test_random;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, width of FIFO read data and output data.
REQ-002 SHALL have parameter BURST_LEN, default 4, number of words popped per burst; legal range 1..ALMOST_GAP+1.
REQ-003 SHALL have parameter ALMOST_GAP, default 3, equal to the ALMOST_GAP of the FIFO whose read side is attached.
REQ-004 SHALL have port clk  input  1  single clock; the FIFO read side runs on this clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rdata  input  DATASIZE  FIFO head word, show-ahead, valid whenever rempty=0.
REQ-007 SHALL have port rempty  input  1  FIFO empty flag, registered in FIFO.
REQ-008 SHALL have port almost_empty  input  1  FIFO holds ALMOST_GAP or fewer words.
REQ-009 SHALL have port rinc  output  1  pop strobe to FIFO; pops rdata in the same cycle.
REQ-010 SHALL have port drain  input  1  level; permit single-word bursts while almost_empty=1.
REQ-011 SHALL have port abort  input  1  synchronous pulse; cancel burst and discard buffered words.
REQ-012 SHALL have port out_data  output  DATASIZE  stream data.
REQ-013 SHALL have port out_last  output  1  out_data is final word of its burst.
REQ-014 SHALL have port out_valid  output  1  stream valid.
REQ-015 SHALL have port out_ready  input  1  stream ready; transfer when out_valid=1 and out_ready=1.
REQ-016 SHALL have port busy  output  1  state is not IDLE.
REQ-017 SHALL have port words_read  output  16  count of FIFO pops since reset, wraps at 2^16.

Function
REQ-018 SHALL implement states IDLE, BURST, FLUSH; state, counters and buffer registered on posedge clk.
REQ-019 IDLE -> BURST with beats=BURST_LEN when almost_empty=0; else IDLE -> BURST with beats=1 when drain=1 and rempty=0; else stay IDLE.
REQ-020 SHALL drive rinc = (state==BURST) && !rempty && (buffer occupancy < 2) && !abort, combinationally, with no dependence on out_ready.
REQ-021 Each rinc SHALL push {last, rdata} into a 2-entry output buffer, with last=1 when beats==1, and decrement beats.
REQ-022 BURST -> FLUSH on the cycle rinc pops the beat with beats==1; BURST stays while waiting on rempty=1 or a full buffer.
REQ-023 FLUSH -> IDLE when the buffer is empty; a new burst SHALL NOT start until then.
REQ-024 out_valid SHALL equal (occupancy != 0); out_data/out_last SHALL show the oldest entry; order preserved.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; occupancy SHALL never exceed 2 nor underflow.
REQ-026 out_data/out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 words_read SHALL increment by 1 on every rinc cycle; 16'hFFFF+1 -> 0.
REQ-028 abort=1 SHALL force state IDLE, occupancy 0 and beats 0 next cycle, with rinc=0 in the abort cycle; words_read SHALL be unaffected.
REQ-029 abort SHALL take priority over every other transition and any simultaneous push/pop.
REQ-030 First rinc of a burst SHALL occur no earlier than the cycle after IDLE->BURST; latency from pop to out_valid SHALL be 1 cycle.

Reset
REQ-031 While rst_n=0: state IDLE, occupancy 0, beats 0, words_read 0, rinc 0, out_valid 0, out_last 0, out_data 0, busy 0.
REQ-032 Reset assertion mid-burst SHALL discard buffered data immediately with no further pops; operation resumes from IDLE after release.

Verification
REQ-033 FIFO preloaded with 8 words 0x10..0x17 (almost_empty=0), out_ready=1 -> two bursts; out 0x10..0x17 in order, out_last on 0x13 and 0x17, words_read=8.
REQ-034 Same preload, out_ready=0 for 20 cycles -> exactly 2 pops, rinc held 0, out_data=0x10 stable; release -> remaining 6 words in order with no loss.
REQ-035 FIFO holds 2 words (almost_empty=1), drain=0 -> no rinc for 50 cycles; raise drain -> two single-word bursts, each with out_last=1.
REQ-036 abort asserted the cycle after the 2nd pop of a 4-beat burst -> out_valid=0 next cycle, state IDLE, words_read=2, next burst restarts at FIFO word 3.
REQ-037 rst_n pulsed low mid-burst -> all outputs at reset values asynchronously, no rinc until rst_n high and almost_empty=0.
REQ-038 words_read preset near wrap via 65540 pops -> reads 4 after wrap; random out_ready backpressure over 10k words -> scoreboard match, occupancy <= 2.
